// File: rtl/hdmi_audio_sample_packetizer_pkg.sv
// Shared types and constants for the HDMI audio sample packetizer.
// The file also holds the IEC 60958 parity and subpacket assembly helpers.
package hdmi_audio_pkg;

  localparam logic [7:0] AUDIO_SAMPLE_PACKET_TYPE = 8'h02;
  localparam int         CS_BLOCK_FRAMES          = 192;
  localparam int         CS_COPYRIGHT_BIT         = 2;
  localparam int         CS_CATEGORY_OFFSET       = 8;
  localparam int         CS_CHANNEL_OFFSET        = 20;
  localparam int         CS_FREQ_OFFSET           = 24;
  localparam int         CS_WORD_LENGTH_OFFSET    = 32;
  localparam logic [3:0] CHANNEL_LEFT             = 4'd1;
  localparam logic [3:0] CHANNEL_RIGHT            = 4'd2;

  typedef logic [55:0] subpacket_t;
  typedef logic [23:0] header_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packetizerState_t;

  // Even parity: the 24 sample bits, V, U, C and P together XOR to zero.
  function automatic logic iecParity(input logic [23:0] sample, input logic v,
                                     input logic u, input logic c);
    return ^{sample, v, u, c};
  endfunction

  // SB6 = {P.R, C.R, U.R, V.R, P.L, C.L, U.L, V.L}; V and U are always 0.
  function automatic subpacket_t buildSubpacket(input logic [15:0] left, input logic [15:0] right,
                                                input logic csLeft, input logic csRight);
    logic [23:0] leftWord;
    logic [23:0] rightWord;
    logic [3:0]  leftFlags;
    logic [3:0]  rightFlags;
    leftWord   = {left, 8'h00};
    rightWord  = {right, 8'h00};
    leftFlags  = {iecParity(leftWord, 1'b0, 1'b0, csLeft), csLeft, 1'b0, 1'b0};
    rightFlags = {iecParity(rightWord, 1'b0, 1'b0, csRight), csRight, 1'b0, 1'b0};
    return {rightFlags, leftFlags, rightWord, leftWord};
  endfunction

endpackage

// File: rtl/hdmi_audio_sample_packetizer_if.sv
// FIFO read side and packet output handshake of the audio sample packetizer.
// The master modport is the packetizer's view; the slave modport is the view of the FIFO and scheduler.
interface hdmi_audio_sample_packetizer_if;
  import hdmi_audio_pkg::*;

  logic        sampleFifoEmpty;
  logic [31:0] sampleFifoReadData;
  logic        sampleFifoReadEnable;
  logic        packetValid;
  logic        packetReady;
  header_t     packetHeader;
  subpacket_t  packetSubpacket0;
  subpacket_t  packetSubpacket1;
  subpacket_t  packetSubpacket2;
  subpacket_t  packetSubpacket3;

  modport master (
    input  sampleFifoEmpty, sampleFifoReadData, packetReady,
    output sampleFifoReadEnable, packetValid, packetHeader,
    output packetSubpacket0, packetSubpacket1, packetSubpacket2, packetSubpacket3
  );

  modport slave (
    output sampleFifoEmpty, sampleFifoReadData, packetReady,
    input  sampleFifoReadEnable, packetValid, packetHeader,
    input  packetSubpacket0, packetSubpacket1, packetSubpacket2, packetSubpacket3
  );
endinterface

// File: rtl/hdmi_audio_sample_packetizer_cs.sv
// Combinational lookup of one IEC 60958 consumer channel-status bit for a given frame of the 192-frame block.
module iec60958_channel_status_bit
  import hdmi_audio_pkg::*;
(
  input  logic [7:0] frameIndex,
  input  logic [3:0] channel,
  input  logic [7:0] category,
  input  logic [3:0] samplingFreq,
  input  logic [3:0] wordLength,
  output logic       csBit
);

  logic [2:0] categoryIdx;
  logic [1:0] channelIdx;
  logic [1:0] freqIdx;
  logic [1:0] wordLengthIdx;

  assign categoryIdx   = 3'(frameIndex - 8'(CS_CATEGORY_OFFSET));
  assign channelIdx    = 2'(frameIndex - 8'(CS_CHANNEL_OFFSET));
  assign freqIdx       = 2'(frameIndex - 8'(CS_FREQ_OFFSET));
  assign wordLengthIdx = 2'(frameIndex - 8'(CS_WORD_LENGTH_OFFSET));

  // Field decode; every multi-bit field is sent LSB first.
  always_comb begin
    csBit = 1'b0;
    if (frameIndex == 8'(CS_COPYRIGHT_BIT)) begin
      csBit = 1'b1;
    end else if (frameIndex >= 8'(CS_CATEGORY_OFFSET) && frameIndex < 8'(CS_CATEGORY_OFFSET + 8)) begin
      csBit = category[categoryIdx];
    end else if (frameIndex >= 8'(CS_CHANNEL_OFFSET) && frameIndex < 8'(CS_CHANNEL_OFFSET + 4)) begin
      csBit = channel[channelIdx];
    end else if (frameIndex >= 8'(CS_FREQ_OFFSET) && frameIndex < 8'(CS_FREQ_OFFSET + 4)) begin
      csBit = samplingFreq[freqIdx];
    end else if (frameIndex >= 8'(CS_WORD_LENGTH_OFFSET) && frameIndex < 8'(CS_WORD_LENGTH_OFFSET + 4)) begin
      csBit = wordLength[wordLengthIdx];
    end else begin
      csBit = 1'b0;
    end
  end

endmodule

// File: rtl/hdmi_audio_sample_packetizer.sv
// Assembles stereo 16-bit samples from a first-word-fall-through FIFO into HDMI Audio Sample Packets.
// Each packet carries up to MAX_SAMPLES IEC 60958 frames and is handed downstream over valid/ready.
module hdmi_audio_sample_packetizer
  import hdmi_audio_pkg::*;
#(
  parameter int MAX_SAMPLES = 4
) (
  input  logic                                  pixelClock,
  input  logic                                  reset,
  hdmi_audio_sample_packetizer_if.master        audioBus,
  input  logic                                  flush,
  input  logic [7:0]                            spdifCategoryCode,
  input  logic [3:0]                            spdifSamplingFreq,
  input  logic [3:0]                            spdifWordLength
);

  localparam logic [2:0] MAX_COUNT = 3'(MAX_SAMPLES);

  packetizerState_t state;
  packetizerState_t nextState;
  logic [2:0]       count;
  logic [2:0]       postCount;
  logic [7:0]       frameIndex;
  logic [7:0]       nextFrameIndex;
  header_t          header;
  subpacket_t       subpackets [0:3];
  logic             pop;
  logic             holding;
  logic             csLeft;
  logic             csRight;

  iec60958_channel_status_bit leftStatus (
    .frameIndex   (frameIndex),
    .channel      (CHANNEL_LEFT),
    .category     (spdifCategoryCode),
    .samplingFreq (spdifSamplingFreq),
    .wordLength   (spdifWordLength),
    .csBit        (csLeft)
  );

  iec60958_channel_status_bit rightStatus (
    .frameIndex   (frameIndex),
    .channel      (CHANNEL_RIGHT),
    .category     (spdifCategoryCode),
    .samplingFreq (spdifSamplingFreq),
    .wordLength   (spdifWordLength),
    .csBit        (csRight)
  );

  // State register.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= nextState;
    end
  end

  // Next state: close on a full packet or on flush with something collected.
  always_comb begin
    nextState = state;
    case (state)
      COLLECT: begin
        if ((pop && postCount == MAX_COUNT) || (flush && postCount != 3'd0)) begin
          nextState = HOLD;
        end else begin
          nextState = COLLECT;
        end
      end
      HOLD: begin
        if (audioBus.packetReady) begin
          nextState = COLLECT;
        end else begin
          nextState = HOLD;
        end
      end
      default: nextState = COLLECT;
    endcase
  end

  // Outputs: the pop strobe is held off during reset so nothing is lost from the FIFO.
  always_comb begin
    pop     = 1'b0;
    holding = 1'b0;
    case (state)
      COLLECT: begin
        if (!reset && !audioBus.sampleFifoEmpty && count < MAX_COUNT) begin
          pop = 1'b1;
        end else begin
          pop = 1'b0;
        end
      end
      HOLD:    holding = 1'b1;
      default: pop = 1'b0;
    endcase
  end

  // Post-pop count and frame index (wraps at the end of the channel-status block).
  always_comb begin
    postCount = count + {2'b00, pop};
    if (frameIndex == 8'(CS_BLOCK_FRAMES - 1)) begin
      nextFrameIndex = 8'd0;
    end else begin
      nextFrameIndex = frameIndex + 8'd1;
    end
  end

  // Packet contents; frameIndex survives packet transfer and flush.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      count      <= 3'd0;
      frameIndex <= 8'd0;
      header     <= 24'h000000;
      for (int k = 0; k < 4; k++) begin
        subpackets[k] <= 56'h0;
      end
    end else if (state == HOLD) begin
      if (audioBus.packetReady) begin
        count  <= 3'd0;
        header <= 24'h000000;
        for (int k = 0; k < 4; k++) begin
          subpackets[k] <= 56'h0;
        end
      end
    end else if (pop) begin
      subpackets[count[1:0]] <= buildSubpacket(audioBus.sampleFifoReadData[31:16],
                                               audioBus.sampleFifoReadData[15:0], csLeft, csRight);
      count                        <= postCount;
      frameIndex                   <= nextFrameIndex;
      header[7:0]                  <= AUDIO_SAMPLE_PACKET_TYPE;
      header[{3'b010, count[1:0]}] <= 1'b1;
      if (frameIndex == 8'd0) begin
        header[{3'b101, count[1:0]}] <= 1'b1;
      end
    end
  end

  assign audioBus.sampleFifoReadEnable = pop;
  assign audioBus.packetValid          = holding;
  assign audioBus.packetHeader         = header;
  assign audioBus.packetSubpacket0     = subpackets[0];
  assign audioBus.packetSubpacket1     = subpackets[1];
  assign audioBus.packetSubpacket2     = subpackets[2];
  assign audioBus.packetSubpacket3     = subpackets[3];

endmodule

// File: tb/tb_hdmi_audio_sample_packetizer.sv
// Directed self-checking bench for hdmi_audio_sample_packetizer with a first-word-fall-through FIFO model.
module tb_hdmi_audio_sample_packetizer;

  logic        pixelClock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  spdifCategoryCode = 8'h00;
  logic [3:0]  spdifSamplingFreq = 4'h0;
  logic [3:0]  spdifWordLength = 4'h0;

  int          testsRun = 0;
  int          testsFailed = 0;

  logic [31:0] fifoQ [$];
  bit          popPending = 1'b0;
  int          popEdges = 0;

  logic [23:0] capHdr [0:49];
  logic [55:0] capSp [0:199];
  int          nPkt;

  hdmi_audio_sample_packetizer_if bus ();

  hdmi_audio_sample_packetizer #(.MAX_SAMPLES(4)) dut (
    .pixelClock        (pixelClock),
    .reset             (reset),
    .audioBus          (bus),
    .flush             (flush),
    .spdifCategoryCode (spdifCategoryCode),
    .spdifSamplingFreq (spdifSamplingFreq),
    .spdifWordLength   (spdifWordLength)
  );

  always #5 pixelClock = ~pixelClock;

  task automatic refreshFifo();
    bus.sampleFifoEmpty    = (fifoQ.size() == 0);
    bus.sampleFifoReadData = (fifoQ.size() == 0) ? 32'h0 : fifoQ[0];
  endtask

  task automatic pushSample(input logic [15:0] l, input logic [15:0] r);
    fifoQ.push_back({l, r});
    refreshFifo();
  endtask

  always @(posedge pixelClock) begin
    if (bus.sampleFifoReadEnable === 1'b1) begin
      popPending = 1'b1;
      popEdges++;
    end
  end

  always @(negedge pixelClock) begin
    if (popPending) begin
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      popPending = 1'b0;
    end
    refreshFifo();
  end

  task automatic doReset();
    @(negedge pixelClock);
    reset = 1'b1;
    flush = 1'b0;
    bus.packetReady = 1'b0;
    fifoQ.delete();
    popPending = 1'b0;
    refreshFifo();
    repeat (2) @(negedge pixelClock);
    reset = 1'b0;
  endtask

  task automatic waitValid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pixelClock);
      if (bus.packetValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pushSample(16'hDEAD, 16'hBEEF);
    #1;
    testsRun++;
    if (bus.sampleFifoReadEnable !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_pop_gate: readEnable=%b expected 0", bus.sampleFifoReadEnable);
    end
    fifoQ.delete();
    refreshFifo();
    @(negedge pixelClock);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pixelClock);
      testsRun++;
      if ({bus.sampleFifoReadEnable, bus.packetValid, bus.packetHeader, bus.packetSubpacket0,
           bus.packetSubpacket1, bus.packetSubpacket2, bus.packetSubpacket3} !== 250'h0) begin
        testsFailed++;
        $display("FAIL idle_outputs cycle %0d: re=%b valid=%b hdr=%h sp0=%h expected all zero",
                 i, bus.sampleFifoReadEnable, bus.packetValid, bus.packetHeader, bus.packetSubpacket0);
      end
    end
  endtask

  task automatic test_full_packet();
    int base;
    bus.packetReady = 1'b1;
    base = popEdges;
    repeat (4) pushSample(16'h1234, 16'h8001);
    for (int i = 0; i < 20 && (popEdges - base) < 4; i++) @(negedge pixelClock);
    testsRun++;
    if (popEdges - base != 4) begin
      testsFailed++;
      $display("FAIL full_pops: got %0d expected 4", popEdges - base);
    end
    testsRun++;
    if (bus.packetValid !== 1'b1) begin
      testsFailed++;
      $display("FAIL full_latency: valid=%b expected 1", bus.packetValid);
    end
    testsRun++;
    if (bus.packetHeader !== 24'h100F02) begin
      testsFailed++;
      $display("FAIL full_header: got %h expected 100f02", bus.packetHeader);
    end
    testsRun++;
    if ({bus.packetSubpacket0, bus.packetSubpacket1, bus.packetSubpacket2, bus.packetSubpacket3} !==
        {56'h08_800100_123400, 56'h08_800100_123400, 56'hC4_800100_123400, 56'h08_800100_123400}) begin
      testsFailed++;
      $display("FAIL full_subpackets: got %h %h %h %h expected 08800100123400 x2, c4800100123400, 08800100123400",
               bus.packetSubpacket0, bus.packetSubpacket1, bus.packetSubpacket2, bus.packetSubpacket3);
    end
    @(negedge pixelClock);
    testsRun++;
    if (bus.packetValid !== 1'b0) begin
      testsFailed++;
      $display("FAIL full_one_cycle: valid=%b expected 0", bus.packetValid);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int pe;
    bit ok;
    logic [247:0] snap;
    bus.packetReady = 1'b0;
    base = popEdges;
    for (int i = 0; i < 10; i++) pushSample(16'(16'h0100 + i), 16'(16'h0200 + i));
    waitValid(30, ok);
    testsRun++;
    if (!ok || popEdges - base != 4) begin
      testsFailed++;
      $display("FAIL bp_first_packet: valid=%b pops=%0d expected 1 and 4", ok, popEdges - base);
    end
    snap = {bus.packetHeader, bus.packetSubpacket0, bus.packetSubpacket1, bus.packetSubpacket2,
            bus.packetSubpacket3};
    pe = popEdges;
    for (int i = 0; i < 20; i++) begin
      @(negedge pixelClock);
      testsRun++;
      if ({bus.packetValid, bus.sampleFifoReadEnable, bus.packetHeader, bus.packetSubpacket0,
           bus.packetSubpacket1, bus.packetSubpacket2, bus.packetSubpacket3} !== {2'b10, snap}) begin
        testsFailed++;
        $display("FAIL bp_stable cycle %0d: valid=%b re=%b hdr=%h expected 1 0 %h",
                 i, bus.packetValid, bus.sampleFifoReadEnable, bus.packetHeader, snap[247:224]);
      end
      testsRun++;
      if (popEdges != pe) begin
        testsFailed++;
        $display("FAIL bp_no_pop cycle %0d: pops=%0d expected %0d", i, popEdges, pe);
      end
    end
    bus.packetReady = 1'b1;
    @(negedge pixelClock);
    testsRun++;
    if (bus.packetValid !== 1'b0 || popEdges != pe) begin
      testsFailed++;
      $display("FAIL bp_transfer_edge: valid=%b pops=%0d expected 0 and %0d", bus.packetValid, popEdges, pe);
    end
    for (int i = 0; i < 10 && popEdges == pe; i++) @(negedge pixelClock);
    testsRun++;
    if (popEdges <= pe) begin
      testsFailed++;
      $display("FAIL bp_resume: pops=%0d expected more than %0d", popEdges, pe);
    end
    waitValid(20, ok);
    testsRun++;
    if (!ok || bus.packetHeader !== 24'h000F02 || popEdges - base != 8) begin
      testsFailed++;
      $display("FAIL bp_second_packet: valid=%b hdr=%h pops=%0d expected 1 000f02 8",
               ok, bus.packetHeader, popEdges - base);
    end
  endtask

  task automatic test_flush();
    int base;
    doReset();
    base = popEdges;
    pushSample(16'h0001, 16'h0000);
    pushSample(16'h0001, 16'h0000);
    for (int i = 0; i < 20 && (popEdges - base) < 2; i++) @(negedge pixelClock);
    flush = 1'b1;
    @(negedge pixelClock);
    flush = 1'b0;
    testsRun++;
    if (bus.packetValid !== 1'b1 || bus.packetHeader !== 24'h100302) begin
      testsFailed++;
      $display("FAIL flush_header: valid=%b hdr=%h expected 1 100302", bus.packetValid, bus.packetHeader);
    end
    testsRun++;
    if ({bus.packetSubpacket2, bus.packetSubpacket3} !== 112'h0) begin
      testsFailed++;
      $display("FAIL flush_unused: sp2=%h sp3=%h expected 0", bus.packetSubpacket2, bus.packetSubpacket3);
    end
    bus.packetReady = 1'b1;
    @(negedge pixelClock);
    bus.packetReady = 1'b0;
    base = popEdges;
    pushSample(16'h00FF, 16'h0000);
    for (int i = 0; i < 20 && (popEdges - base) < 1; i++) @(negedge pixelClock);
    flush = 1'b1;
    @(negedge pixelClock);
    flush = 1'b0;
    testsRun++;
    if (bus.packetValid !== 1'b1 || bus.packetHeader !== 24'h000102 ||
        bus.packetSubpacket0 !== 56'hCC_000000_00FF00) begin
      testsFailed++;
      $display("FAIL flush_frame2: valid=%b hdr=%h sp0=%h expected 1 000102 cc00000000ff00",
               bus.packetValid, bus.packetHeader, bus.packetSubpacket0);
    end
    bus.packetReady = 1'b1;
    @(negedge pixelClock);
    bus.packetReady = 1'b0;
    flush = 1'b1;
    @(negedge pixelClock);
    flush = 1'b0;
    @(negedge pixelClock);
    testsRun++;
    if (bus.packetValid !== 1'b0) begin
      testsFailed++;
      $display("FAIL flush_empty_ignored: valid=%b expected 0", bus.packetValid);
    end
  endtask

  task automatic test_channel_status_block();
    int bOther;
    doReset();
    spdifCategoryCode = 8'h81;
    spdifSamplingFreq = 4'd2;
    spdifWordLength   = 4'hB;
    bus.packetReady   = 1'b1;
    for (int f = 0; f < 200; f++) pushSample(16'(16'hA000 + f), 16'(16'h5000 + f));
    nPkt = 0;
    for (int i = 0; i < 1500 && nPkt < 50; i++) begin
      @(negedge pixelClock);
      if (bus.packetValid === 1'b1) begin
        capHdr[nPkt]      = bus.packetHeader;
        capSp[4*nPkt]     = bus.packetSubpacket0;
        capSp[4*nPkt + 1] = bus.packetSubpacket1;
        capSp[4*nPkt + 2] = bus.packetSubpacket2;
        capSp[4*nPkt + 3] = bus.packetSubpacket3;
        nPkt++;
      end
    end
    testsRun++;
    if (nPkt != 50) begin
      testsFailed++;
      $display("FAIL cs_packet_count: got %0d expected 50", nPkt);
    end
    bOther = 0;
    for (int p = 1; p < nPkt; p++) if (p != 48 && capHdr[p][23:16] !== 8'h00) bOther++;
    testsRun++;
    if ({capHdr[0][23:16], capHdr[48][23:16]} !== 16'h1010 || bOther != 0) begin
      testsFailed++;
      $display("FAIL cs_block_start: hb2[0]=%h hb2[48]=%h others=%0d expected 10 10 0",
               capHdr[0][23:16], capHdr[48][23:16], bOther);
    end
    testsRun++;
    if ({capSp[20][50], capSp[21][50], capSp[22][50], capSp[23][50]} !== 4'b1000) begin
      testsFailed++;
      $display("FAIL cs_channel_left: got %b%b%b%b expected 1000",
               capSp[20][50], capSp[21][50], capSp[22][50], capSp[23][50]);
    end
    testsRun++;
    if ({capSp[20][54], capSp[21][54], capSp[22][54], capSp[23][54]} !== 4'b0100) begin
      testsFailed++;
      $display("FAIL cs_channel_right: got %b%b%b%b expected 0100",
               capSp[20][54], capSp[21][54], capSp[22][54], capSp[23][54]);
    end
    testsRun++;
    if ({capSp[24][50], capSp[25][50], capSp[26][50], capSp[27][50], capSp[25][54]} !== 5'b01001) begin
      testsFailed++;
      $display("FAIL cs_freq: got %b%b%b%b R25=%b expected 0100 1",
               capSp[24][50], capSp[25][50], capSp[26][50], capSp[27][50], capSp[25][54]);
    end
    testsRun++;
    if ({capSp[8][50], capSp[9][50], capSp[10][50], capSp[11][50], capSp[12][50], capSp[13][50],
         capSp[14][50], capSp[15][50]} !== 8'b10000001) begin
      testsFailed++;
      $display("FAIL cs_category: got %b%b%b%b%b%b%b%b expected 10000001", capSp[8][50], capSp[9][50],
               capSp[10][50], capSp[11][50], capSp[12][50], capSp[13][50], capSp[14][50], capSp[15][50]);
    end
    testsRun++;
    if ({capSp[32][50], capSp[33][50], capSp[34][50], capSp[35][50]} !== 4'b1101) begin
      testsFailed++;
      $display("FAIL cs_word_length: got %b%b%b%b expected 1101",
               capSp[32][50], capSp[33][50], capSp[34][50], capSp[35][50]);
    end
    testsRun++;
    if ({capSp[2][50], capSp[192][50], capSp[194][50], capSp[194][54]} !== 4'b1011) begin
      testsFailed++;
      $display("FAIL cs_wrap: f2=%b f192=%b f194=%b%b expected 1 0 11",
               capSp[2][50], capSp[192][50], capSp[194][50], capSp[194][54]);
    end
    testsRun++;
    if (capSp[30] !== 56'h00_501E00_A01E00 || capSp[20] !== 56'h0C_501400_A01400) begin
      testsFailed++;
      $display("FAIL cs_payload: f30=%h f20=%h expected 00501e00a01e00 0c501400a01400",
               capSp[30], capSp[20]);
    end
    testsRun++;
    if (capHdr[49] !== 24'h000F02) begin
      testsFailed++;
      $display("FAIL cs_last_header: got %h expected 000f02", capHdr[49]);
    end
  endtask

  task automatic test_reset_in_hold();
    bit ok;
    bus.packetReady = 1'b0;
    repeat (4) pushSample(16'h4444, 16'h5555);
    waitValid(30, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("FAIL hold_reach: valid=%b expected 1", ok);
    end
    #2;
    reset = 1'b1;
    fifoQ.delete();
    popPending = 1'b0;
    refreshFifo();
    #1;
    testsRun++;
    if (bus.packetValid !== 1'b0 || bus.packetHeader !== 24'h000000) begin
      testsFailed++;
      $display("FAIL async_reset: valid=%b hdr=%h expected 0 000000", bus.packetValid, bus.packetHeader);
    end
    @(negedge pixelClock);
    reset = 1'b0;
    bus.packetReady = 1'b1;
    repeat (4) pushSample(16'h4444, 16'h5555);
    waitValid(30, ok);
    testsRun++;
    if (!ok || bus.packetHeader !== 24'h100F02) begin
      testsFailed++;
      $display("FAIL post_reset_block: valid=%b hdr=%h expected 1 100f02", ok, bus.packetHeader);
    end
  endtask

  initial begin
    bus.packetReady = 1'b0;
    refreshFifo();
    test_reset();
    test_full_packet();
    test_backpressure();
    test_flush();
    test_channel_status_block();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
